image_buffer_writer: RTL and testbench

IMAGE_BUFFER_WRITER -- requirements
Module: image_buffer_writer

---
 rtl/image_buffer_writer.sv | 198 +++++++++++++++++++
 tb/tb_image_buffer_writer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_buffer_writer.sv
// image_buffer_writer
//   Captures one source frame of RGB pixels into an image RAM after a start pulse.
//   Capture begins at the first pixel flagged pix_sof. Each accepted pixel is
//   written to RAM one cycle later.
//
//   Optional feature (macro BOUNDARY_CROP_EN):
//     defined   - only pixels inside the window that starts at (win_x, win_y) and
//                 is p_image_width x p_image_height in size are stored. The source
//                 frame is p_src_width x p_src_height.
//     undefined - win_x and win_y are ignored. Every pixel is stored, the source
//                 frame is p_image_width x p_image_height, and wr_addr is the
//                 sequential pixel index.
//
//   Ports:
//     clk, reset           clock; asynchronous active-high reset
//     start                one-cycle pulse; arms capture (accepted only when idle)
//     win_x, win_y         window top-left corner, sampled on an accepted start
//     pix_valid, pix_sof   source handshake and start-of-frame qualifier
//     pix_data             {R,G,B} source pixel
//     pix_ready            writer accepts a pixel this cycle
//     wr_en, wr_addr,      RAM write port
//     wr_data
//     busy                 high whenever the writer is not idle
//     frame_done           single-cycle pulse at the end of a frame
//     sof_error            single-cycle pulse when pix_sof arrives mid-frame
module image_buffer_writer #(
  parameter int unsigned p_image_width  = 80,
  parameter int unsigned p_image_height = 480,
  parameter int unsigned p_src_width    = 640,
  parameter int unsigned p_src_height   = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] win_x,
  input  logic [10:0] win_y,
  input  logic        pix_valid,
  input  logic        pix_sof,
  input  logic [23:0] pix_data,
  output logic        pix_ready,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [23:0] wr_data,
  output logic        busy,
  output logic        frame_done,
  output logic        sof_error
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_SOF = 2'd1;
  localparam logic [1:0] S_CAPTURE  = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

`ifdef BOUNDARY_CROP_EN
  localparam int unsigned SRC_W = p_src_width;
  localparam int unsigned SRC_H = p_src_height;
`else
  localparam int unsigned SRC_W = p_image_width;
  localparam int unsigned SRC_H = p_image_height;
`endif

  localparam logic [10:0] SRC_X_LAST = 11'(SRC_W - 1);
  localparam logic [10:0] SRC_Y_LAST = 11'(SRC_H - 1);
  localparam logic [15:0] IMG_W16    = 16'(p_image_width);

  logic [1:0]  state;
  logic [1:0]  state_nx;
  // Coordinate of the next pixel expected in the source frame.
  logic [10:0] src_x;
  logic [10:0] src_y;

  logic        xfer;
  logic        take_pix;
  logic        start_acc;
  logic        sof_err_nx;
  logic [10:0] cur_x;
  logic [10:0] cur_y;
  logic        last_pix;
  logic        in_win;
  logic [15:0] pix_addr;

  assign xfer     = pix_valid && pix_ready;
  // A pixel flagged pix_sof is always source (0,0), even in the middle of a frame.
  assign cur_x    = pix_sof ? 11'd0 : src_x;
  assign cur_y    = pix_sof ? 11'd0 : src_y;
  assign last_pix = (cur_x == SRC_X_LAST) && (cur_y == SRC_Y_LAST);

`ifdef BOUNDARY_CROP_EN
  logic [10:0] win_x_q;
  logic [10:0] win_y_q;
  logic [11:0] win_x_hi;
  logic [11:0] win_y_hi;
  logic [10:0] rel_x;
  logic [10:0] rel_y;

  // The window bounds are 12 bits wide, so a window near 2047 never wraps back into range.
  assign win_x_hi = {1'b0, win_x_q} + 12'(p_image_width);
  assign win_y_hi = {1'b0, win_y_q} + 12'(p_image_height);
  assign in_win   = ({1'b0, cur_x} >= {1'b0, win_x_q}) && ({1'b0, cur_x} < win_x_hi) &&
                    ({1'b0, cur_y} >= {1'b0, win_y_q}) && ({1'b0, cur_y} < win_y_hi);
  assign rel_x    = cur_x - win_x_q;
  assign rel_y    = cur_y - win_y_q;
  assign pix_addr = 16'(rel_x) + IMG_W16 * 16'(rel_y);

  // Window latch, loaded only on an accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_x_q <= 11'd0;
      win_y_q <= 11'd0;
    end else if (start_acc) begin
      win_x_q <= win_x;
      win_y_q <= win_y;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{win_x, win_y, 16'(p_src_width), 16'(p_src_height)};
  assign in_win     = 1'b1;
  assign pix_addr   = 16'(cur_x) + IMG_W16 * 16'(cur_y);
`endif

  // Next-state logic and per-cycle strobes.
  always_comb begin
    state_nx   = state;
    start_acc  = 1'b0;
    take_pix   = 1'b0;
    sof_err_nx = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nx  = S_WAIT_SOF;
        end
      end
      S_WAIT_SOF: begin
        if (xfer && pix_sof) begin
          take_pix = 1'b1;
          state_nx = last_pix ? S_DONE : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (xfer) begin
          take_pix   = 1'b1;
          sof_err_nx = pix_sof;
          if (last_pix) begin
            state_nx = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      src_x      <= 11'd0;
      src_y      <= 11'd0;
      pix_ready  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      sof_error  <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= 16'd0;
      wr_data    <= 24'd0;
    end else begin
      state      <= state_nx;
      pix_ready  <= (state_nx == S_WAIT_SOF) || (state_nx == S_CAPTURE);
      busy       <= (state_nx != S_IDLE);
      frame_done <= (state_nx == S_DONE);
      sof_error  <= sof_err_nx;
      wr_en      <= take_pix && in_win;
      if (take_pix && in_win) begin
        wr_addr <= pix_addr;
        wr_data <= pix_data;
      end
      if (start_acc) begin
        src_x <= 11'd0;
        src_y <= 11'd0;
      end else if (take_pix) begin
        if (cur_x == SRC_X_LAST) begin
          src_x <= 11'd0;
          src_y <= (cur_y == SRC_Y_LAST) ? 11'd0 : cur_y + 11'd1;
        end else begin
          src_x <= cur_x + 11'd1;
          src_y <= cur_y;
        end
      end
    end
  end

endmodule

// File: tb/tb_image_buffer_writer.sv
// Bench for image_buffer_writer. It uses a small geometry: an 8x6 image and a 16x12 source.
// Each pixel's data carries its own source coordinate, so the bench can derive every
// expected write address from the data it observes on the write port.
module tb_image_buffer_writer;

  localparam int IW = 8;
  localparam int IH = 6;
  localparam int SW = 16;
  localparam int SH = 12;
`ifdef BOUNDARY_CROP_EN
  localparam int FW = SW;
  localparam int FH = SH;
`else
  localparam int FW = IW;
  localparam int FH = IH;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [10:0] win_x = 11'd0;
  logic [10:0] win_y = 11'd0;
  logic        pix_valid = 1'b0;
  logic        pix_sof = 1'b0;
  logic [23:0] pix_data = 24'd0;
  logic        pix_ready;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [23:0] wr_data;
  logic        busy;
  logic        frame_done;
  logic        sof_error;

  image_buffer_writer #(
    .p_image_width (IW),
    .p_image_height(IH),
    .p_src_width   (SW),
    .p_src_height  (SH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .win_x     (win_x),
    .win_y     (win_y),
    .pix_valid (pix_valid),
    .pix_sof   (pix_sof),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .frame_done(frame_done),
    .sof_error (sof_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] wx;
    logic [10:0] wy;
    int          junk;
    bit          rnd;
    int          n_wr;
    int          first_addr;
    int          first_data;
    int          last_addr;
    int          last_data;
    bit          done_wr;
  } vec_t;

  int total = 0;
  int bad   = 0;

  int cur_wx = 0;
  int cur_wy = 0;
  int n_wr, n_done, n_sof, first_addr, first_data, last_addr, last_data;
  bit done_wr, sof_wr_en;
  int sof_addr, sof_data;
  int mx, my;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [23:0] px(input int x, input int y);
    return {8'h5A, 8'(y), 8'(x)};
  endfunction

  task automatic clear_stats();
    n_wr = 0; n_done = 0; n_sof = 0;
    first_addr = -1; first_data = -1; last_addr = -1; last_data = -1;
    done_wr = 1'b0; sof_wr_en = 1'b0; sof_addr = -1; sof_data = -1;
  endtask

  // Write-port monitor: each write must belong to the window and land at its coordinate's address.
  always @(negedge clk) begin
    if (wr_en) begin
      mx = int'(wr_data[7:0]);
      my = int'(wr_data[15:8]);
`ifdef BOUNDARY_CROP_EN
      chk("wr_in_window", (mx >= cur_wx && mx < cur_wx + IW && my >= cur_wy && my < cur_wy + IH) ? 1 : 0, 1);
      chk("wr_addr", int'(wr_addr), (mx - cur_wx) + IW * (my - cur_wy));
`else
      chk("wr_addr", int'(wr_addr), mx + IW * my);
`endif
      chk("wr_tag", int'(wr_data[23:16]), 'h5A);
      if (n_wr == 0) begin
        first_addr = int'(wr_addr);
        first_data = int'(wr_data);
      end
      last_addr = int'(wr_addr);
      last_data = int'(wr_data);
      n_wr++;
    end
    if (frame_done) begin
      n_done++;
      if (wr_en) done_wr = 1'b1;
    end
    if (sof_error) begin
      n_sof++;
      sof_wr_en = wr_en;
      sof_addr  = int'(wr_addr);
      sof_data  = int'(wr_data);
    end
  end

  // Present one pixel and hold it until it transfers. With rnd set, idle cycles
  // (sometimes carrying a start pulse for a different window) are inserted first.
  task automatic send_pixel(input logic [23:0] d, input bit sof, input bit rnd);
    int g;
    if (rnd) begin
      while ($urandom_range(0, 1) == 1) begin
        pix_valid = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
          start = 1'b1;
          win_x = 11'd3;
          win_y = 11'd3;
        end
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = sof;
    g = 0;
    while (!pix_ready && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 20) chk("ready_timeout", 0, 1);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic pulse_start(input logic [10:0] wx, input logic [10:0] wy);
    win_x = wx;
    win_y = wy;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    win_x = 11'd5;
    win_y = 11'd7;
    cur_wx = int'(wx);
    cur_wy = int'(wy);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 10) begin
      @(posedge clk); #1;
      g++;
    end
    chk("idle_timeout", int'(busy), 0);
    @(posedge clk); #1;
  endtask

  task automatic run_row(input vec_t v, input int idx);
    clear_stats();
    pulse_start(v.wx, v.wy);
    for (int j = 0; j < v.junk; j++) send_pixel(px(200 + j, 200), 1'b0, 1'b0);
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < FW; x++)
        send_pixel(px(x, y), (x == 0 && y == 0), v.rnd);
    wait_idle();
    chk($sformatf("row%0d_n_wr", idx), n_wr, v.n_wr);
    chk($sformatf("row%0d_frame_done", idx), n_done, 1);
    chk($sformatf("row%0d_sof_error", idx), n_sof, 0);
    chk($sformatf("row%0d_done_with_write", idx), int'(done_wr), int'(v.done_wr));
    if (v.n_wr > 0) begin
      chk($sformatf("row%0d_first_addr", idx), first_addr, v.first_addr);
      chk($sformatf("row%0d_first_data", idx), first_data, v.first_data);
      chk($sformatf("row%0d_last_addr", idx), last_addr, v.last_addr);
      chk($sformatf("row%0d_last_data", idx), last_data, v.last_data);
    end
  endtask

  vec_t vecs[6];
  int   nv;

  initial begin
`ifdef BOUNDARY_CROP_EN
    vecs[0] = '{11'd0,    11'd0,    0, 1'b0, 48, 0, int'(px(0, 0)),   47, int'(px(7, 5)),   1'b0};
    vecs[1] = '{11'd12,   11'd9,    3, 1'b0, 12, 0, int'(px(12, 9)),  19, int'(px(15, 11)), 1'b1};
    vecs[2] = '{11'd4,    11'd3,    0, 1'b1, 48, 0, int'(px(4, 3)),   47, int'(px(11, 8)),  1'b0};
    vecs[3] = '{11'd16,   11'd0,    0, 1'b0, 0,  0, 0,                0,  0,                1'b0};
    vecs[4] = '{11'd2047, 11'd2047, 2, 1'b0, 0,  0, 0,                0,  0,                1'b0};
    vecs[5] = '{11'd15,   11'd11,   0, 1'b1, 1,  0, int'(px(15, 11)), 0,  int'(px(15, 11)), 1'b1};
    nv = 6;
`else
    vecs[0] = '{11'd0,    11'd0,    0, 1'b0, 48, 0, int'(px(0, 0)), 47, int'(px(7, 5)), 1'b1};
    vecs[1] = '{11'd12,   11'd9,    3, 1'b0, 48, 0, int'(px(0, 0)), 47, int'(px(7, 5)), 1'b1};
    vecs[2] = '{11'd4,    11'd3,    0, 1'b1, 48, 0, int'(px(0, 0)), 47, int'(px(7, 5)), 1'b1};
    vecs[3] = '{11'd2047, 11'd2047, 2, 1'b1, 48, 0, int'(px(0, 0)), 47, int'(px(7, 5)), 1'b1};
    vecs[4] = vecs[0];
    vecs[5] = vecs[0];
    nv = 4;
`endif
    clear_stats();

    // Reset state, checked before any clock edge.
    #1 reset = 1'b1;
    #2;
    chk("rst_pix_ready", int'(pix_ready), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_sof_error", int'(sof_error), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < nv; i++) run_row(vecs[i], i);

    // pix_sof reasserted at source (5,2): that pixel restarts the frame as (0,0).
    clear_stats();
    pulse_start(11'd0, 11'd0);
    for (int k = 0; k < 2 * FW + 5; k++) send_pixel(px(k % FW, k / FW), (k == 0), 1'b0);
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < FW; x++)
        send_pixel(px(x, y), (x == 0 && y == 0), 1'b0);
    wait_idle();
    chk("sof_err_count", n_sof, 1);
    chk("sof_err_wr_en", int'(sof_wr_en), 1);
    chk("sof_err_addr", sof_addr, 0);
    chk("sof_err_data", sof_data, int'(px(0, 0)));
    chk("sof_err_n_wr", n_wr, 69);
    chk("sof_err_frame_done", n_done, 1);

    // Asynchronous reset in the middle of capture.
    clear_stats();
    pulse_start(11'd0, 11'd0);
    for (int k = 0; k < 30; k++) send_pixel(px(k % FW, k / FW), (k == 0), 1'b0);
    pix_valid = 1'b1;
    pix_data  = px(30 % FW, 30 / FW);
    #1 reset = 1'b1;
    #1;
    chk("midrst_pix_ready", int'(pix_ready), 0);
    chk("midrst_wr_en", int'(wr_en), 0);
    chk("midrst_busy", int'(busy), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    clear_stats();
    for (int k = 0; k < 30; k++) begin
      pix_valid = k[0];
      pix_sof   = (k % 7 == 0);
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    chk("postrst_n_wr", n_wr, 0);
    chk("postrst_frame_done", n_done, 0);
    chk("postrst_sof_error", n_sof, 0);
    chk("postrst_busy", int'(busy), 0);

    // A fresh start after the abort behaves normally.
    run_row(vecs[0], 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
